// File: rtl/keypad_scan_if.sv
// Keypad pin and key-code bundle for keypad_scan.
// master: the scanner (drives columns and the key code, reads rows).
// slave:  the board/consumer side (drives rows, reads columns and the key code).
interface keypad_scan_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;

  modport master (input row, output col, output key, output key_valid);
  modport slave  (output row, input col, input key, input key_valid);
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner with per-frame debounce.
// One frame = four column slots of SCAN_DIV cycles each. The whole frame is
// reduced to a single candidate code, and a four-state FSM debounces that
// candidate across frames.
// Optional feature: define KEY_REPEAT_EN to enable auto-repeat while a key is
// held (REPEAT_DELAY / REPEAT_PERIOD frames).
module keypad_scan #(
  parameter int SCAN_DIV        = 2,
  parameter int DEBOUNCE_FRAMES = 3
`ifdef KEY_REPEAT_EN
  , parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD   = 10
`endif
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scan_if.master kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [3:0] NO_KEY = 4'b1111;

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  // Row/column to key-code map; 1111 in the map means the key is ignored.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = 4'b1010;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = 4'b1011;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = 4'b1100;
      4'd12:   code = 4'b1101;
      4'd13:   code = 4'd0;
      4'd14:   code = 4'b1110;
      default: code = 4'b1111;
    endcase
    return code;
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       nlow_q, nlow_d;      // low rows seen this frame: 0, 1, 2 = two or more
  logic [3:0]       code_q, code_d;      // code of the single low bit seen so far
  logic             slot_end, frame_end;
  logic [3:0]       row_low;
  logic [2:0]       sample_n;
  logic [1:0]       sample_r;
  logic [1:0]       nlow_now;
  logic [3:0]       code_now;
  logic [3:0]       frame_cand;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             cnt_hit;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       key_q, key_d;
  logic             key_valid_q, key_valid_d;

`ifdef KEY_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc, rpt_target;
  logic             first_q, first_d;    // still waiting for the first repeat
  logic             gap_q, gap_d;        // key is in its one-frame 1111 gap
`endif

  // Column timing and per-frame row accumulation; the candidate includes the current sample.
  always_comb begin
    slot_end  = (div_q == DIV_W'(SCAN_DIV - 1));
    frame_end = slot_end && (col_idx_q == 2'd3);
    div_d     = slot_end ? '0 : div_q + DIV_W'(1);
    col_idx_d = slot_end ? col_idx_q + 2'd1 : col_idx_q;
    col_d     = ~(4'b0001 << col_idx_d);

    row_low  = ~kp.row;
    sample_n = 3'(row_low[0]) + 3'(row_low[1]) + 3'(row_low[2]) + 3'(row_low[3]);
    sample_r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (row_low[i]) sample_r = 2'(i);
    end

    nlow_now = nlow_q;
    code_now = code_q;
    if (slot_end) begin
      if (sample_n >= 3'd2) begin
        nlow_now = 2'd2;
      end else if (sample_n == 3'd1) begin
        if (nlow_q == 2'd0) begin
          nlow_now = 2'd1;
          code_now = key_map(sample_r, col_idx_q);
        end else begin
          nlow_now = 2'd2;
        end
      end
    end
    frame_cand = (nlow_now == 2'd1) ? code_now : NO_KEY;
    nlow_d     = frame_end ? 2'd0 : nlow_now;
    code_d     = frame_end ? NO_KEY : code_now;
  end

  // Scan counters, column drive and frame accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      col_idx_q <= 2'd0;
      col_q     <= 4'b1110;
      nlow_q    <= 2'd0;
      code_q    <= NO_KEY;
    end else begin
      div_q     <= div_d;
      col_idx_q <= col_idx_d;
      col_q     <= col_d;
      nlow_q    <= nlow_d;
      code_q    <= code_d;
    end
  end

  // Debounce FSM next-state and outputs, advanced only at frame ends.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    cnt_inc     = cnt_q + CNT_W'(1);
    cnt_hit     = (cnt_inc == CNT_W'(DEBOUNCE_FRAMES));
`ifdef KEY_REPEAT_EN
    rpt_d      = rpt_q;
    first_d    = first_q;
    gap_d      = gap_q;
    rpt_inc    = rpt_q + RPT_W'(1);
    rpt_target = first_q ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD);
    if (state_q != HELD) begin
      rpt_d   = '0;
      first_d = 1'b1;
      gap_d   = 1'b0;
    end
`endif
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (frame_cand != NO_KEY) begin
            cand_d = frame_cand;
            if (DEBOUNCE_FRAMES == 1) begin
              state_d     = HELD;
              key_d       = frame_cand;
              key_valid_d = 1'b1;
            end else begin
              state_d = PRESS_WAIT;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        PRESS_WAIT: begin
          if (frame_cand == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_hit) begin
              state_d     = HELD;
              key_d       = cand_q;
              key_valid_d = 1'b1;
            end
          end else if (frame_cand != NO_KEY) begin
            cand_d = frame_cand;
            cnt_d  = CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (frame_cand != cand_q) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_d = IDLE;
              key_d   = NO_KEY;
            end else begin
              state_d = RELEASE_WAIT;
              cnt_d   = CNT_W'(1);
            end
          end
`ifdef KEY_REPEAT_EN
          else if (gap_q) begin
            key_d       = cand_q;
            key_valid_d = 1'b1;
            gap_d       = 1'b0;
            first_d     = 1'b0;
            rpt_d       = '0;
          end else begin
            rpt_d = rpt_inc;
            if (rpt_inc == rpt_target) begin
              key_d = NO_KEY;
              gap_d = 1'b1;
            end
          end
`endif
        end
        default: begin  // RELEASE_WAIT
          if (frame_cand != cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_hit) begin
              state_d = IDLE;
              key_d   = NO_KEY;
            end
          end else begin
            state_d = HELD;
`ifdef KEY_REPEAT_EN
            // Release was interrupted during a repeat gap: restore the key.
            if (key_q == NO_KEY) begin
              key_d       = cand_q;
              key_valid_d = 1'b1;
            end
`endif
          end
        end
      endcase
    end
  end

  // Debounce FSM state, latched candidate and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= NO_KEY;
      key_q       <= NO_KEY;
      key_valid_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_q       <= '0;
      first_q     <= 1'b1;
      gap_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
`ifdef KEY_REPEAT_EN
      rpt_q       <= rpt_d;
      first_q     <= first_d;
      gap_q       <= gap_d;
`endif
    end
  end

  assign kp.col       = col_q;
  assign kp.key       = key_q;
  assign kp.key_valid = key_valid_q;

endmodule
